// File: rtl/bram_reader.sv
// Burst reader: streams word_count consecutive 32-bit words from a BRAM
// starting at a word-aligned base address, with backpressure via a 2-entry FIFO.
module bram_reader #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [COUNT_WIDTH-1:0] word_count,
    output logic [ADDR_WIDTH-1:0]  bram_address,
    output logic                   bram_enable,
    input  logic [DATA_WIDTH-1:0]  bram_data_in,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [COUNT_WIDTH-1:0] cnt_q;
    logic [COUNT_WIDTH-1:0] issue_cnt;
    logic [COUNT_WIDTH-1:0] hs_cnt;
    logic [ADDR_WIDTH-1:0]  rd_addr;

    logic [DATA_WIDTH-1:0]  fifo_mem [2];
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             fifo_cnt;

    logic                   outstanding;
    logic                   issue;
    logic                   push;
    logic                   pop;
    logic [1:0]             in_use;
    logic                   last_issue;
    logic                   last_hs;
    logic                   unused_addr_bits;

    // Data returns on the edge after the enabled cycle, so the registered
    // enable is exactly the single outstanding-read flag.
    assign outstanding = bram_enable;
    assign push        = outstanding;
    assign pop         = m_valid && m_ready;
    assign in_use      = fifo_cnt + {1'b0, outstanding};
    assign last_issue  = issue && (issue_cnt == cnt_q - 1'b1);
    assign last_hs     = pop && (hs_cnt == cnt_q - 1'b1);

    assign m_valid     = (fifo_cnt != 2'd0);
    assign m_data      = fifo_mem[rd_ptr];

    assign unused_addr_bits = ^base_addr[1:0];

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (word_count == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (last_issue) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (last_hs) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs; a read is issued only when the FIFO is guaranteed a free slot.
    always_comb begin
        busy  = (state != ST_IDLE);
        done  = (state == ST_DONE);
        issue = (state == ST_READ) &&
                ((in_use < 2'd2) || ((in_use == 2'd2) && pop));
    end

    // Burst bookkeeping and the BRAM request port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            issue_cnt    <= '0;
            hs_cnt       <= '0;
            rd_addr      <= '0;
            bram_address <= '0;
            bram_enable  <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && start) begin
                cnt_q     <= word_count;
                rd_addr   <= {base_addr[ADDR_WIDTH-1:2], 2'b00};
                issue_cnt <= '0;
                hs_cnt    <= '0;
            end else begin
                if (issue) begin
                    issue_cnt <= issue_cnt + 1'b1;
                    rd_addr   <= rd_addr + ADDR_WIDTH'(4);
                end
                if (pop) begin
                    hs_cnt <= hs_cnt + 1'b1;
                end
            end
            bram_enable <= issue;
            if (issue) begin
                bram_address <= rd_addr;
            end
        end
    end

    // Two-entry output FIFO
    // NOTE: the storage is only two words, so it is reset too; that makes
    // m_data read 0 out of reset instead of stale contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= bram_data_in;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_reader.sv
// Scoreboard bench for bram_reader: expected addresses and stream words are
// queued at stimulus time and popped by independent negedge monitors.
module tb_bram_reader;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int CW = 16;

    logic          clk        = 1'b0;
    logic          reset_n    = 1'b1;
    logic          start      = 1'b0;
    logic [AW-1:0] base_addr  = '0;
    logic [CW-1:0] word_count = '0;
    logic          m_ready    = 1'b0;
    logic [AW-1:0] bram_address;
    logic          bram_enable;
    logic [DW-1:0] bram_data_in;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;
    int reads_seen = 0;
    int words_seen = 0;

    logic [31:0] exp_addr [$];
    logic [31:0] exp_data [$];

    bram_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .base_addr    (base_addr),
        .word_count   (word_count),
        .bram_address (bram_address),
        .bram_enable  (bram_enable),
        .bram_data_in (bram_data_in),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // BRAM contents used by the directed vectors
    function automatic logic [31:0] bram_word(input logic [31:0] a);
        case (a)
            32'hB000_0000: bram_word = 32'h0000_0001;
            32'hB000_0004: bram_word = 32'h0000_0002;
            32'hB000_0008: bram_word = 32'h0000_0003;
            32'hB000_000C: bram_word = 32'h0000_0004;
            32'hB000_0024: bram_word = 32'h1122_3344;
            32'hB000_0028: bram_word = 32'h5566_7788;
            32'hB000_002C: bram_word = 32'h99AA_BBCC;
            32'hFFFF_FFFC: bram_word = 32'hCAFE_0001;
            32'h0000_0000: bram_word = 32'hCAFE_0002;
            default:       bram_word = a ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    assign bram_data_in = !reset_n ? 32'hFFFF_FFFF :
                          (bram_enable ? bram_word(bram_address) : 32'h0000_0004);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Read-address monitor
    always @(negedge clk) begin
        if (reset_n && bram_enable) begin
            reads_seen++;
            if (exp_addr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_read: got addr 0x%0h expected no read", bram_address);
            end else begin
                check("bram_address", 64'(bram_address), 64'(exp_addr.pop_front()));
            end
        end
    end

    // Stream monitor: one compare per handshake
    always @(negedge clk) begin
        if (reset_n && m_valid && m_ready) begin
            words_seen++;
            if (exp_data.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got 0x%0h expected no word", m_data);
            end else begin
                check("m_data", 64'(m_data), 64'(exp_data.pop_front()));
            end
        end
    end

    task automatic start_burst(input logic [31:0] base, input logic [15:0] cnt);
        @(posedge clk) #1;
        base_addr  = base;
        word_count = cnt;
        start      = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done expected done within 200 cycles", tag);
        end
    endtask

    task automatic queues_empty(input string tag);
        check({tag, "_addr_left"}, 64'(exp_addr.size()), 64'd0);
        check({tag, "_data_left"}, 64'(exp_data.size()), 64'd0);
    endtask

    // Base 0xB0000000, count 4, ready high: cycle-exact trace of the burst
    task automatic run_basic(input string tag);
        logic [7:0] en_tr, val_tr, done_tr, busy_tr;
        for (int i = 0; i < 4; i++) begin
            exp_addr.push_back(32'hB000_0000 + 32'(4 * i));
            exp_data.push_back(32'(i + 1));
        end
        m_ready = 1'b1;
        start_burst(32'hB000_0000, 16'd4);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            en_tr[k]   = bram_enable;
            val_tr[k]  = m_valid;
            done_tr[k] = done;
            busy_tr[k] = busy;
        end
        check({tag, "_enable_trace"}, 64'(en_tr),   64'h1E);
        check({tag, "_valid_trace"},  64'(val_tr),  64'h3C);
        check({tag, "_done_trace"},   64'(done_tr), 64'h40);
        check({tag, "_busy_trace"},   64'(busy_tr), 64'h7F);
        queues_empty(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        int reads_base;
        int words_base;
        bit got_valid;

        // Reset values
        #2 reset_n = 1'b0;
        #1;
        check("rst_outputs", 64'({bram_address, bram_enable, m_data, m_valid, busy, done}), 64'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);

        run_basic("basic");

        // Backpressure: ready low for 5 cycles after first valid
        @(posedge clk) #1 m_ready = 1'b0;
        exp_addr.push_back(32'hB000_0024);
        exp_addr.push_back(32'hB000_0028);
        exp_addr.push_back(32'hB000_002C);
        exp_data.push_back(32'h1122_3344);
        exp_data.push_back(32'h5566_7788);
        exp_data.push_back(32'h99AA_BBCC);
        reads_base = reads_seen;
        words_base = words_seen;
        start_burst(32'hB000_0024, 16'd3);
        got_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_valid) begin
                got_valid = 1'b1;
                break;
            end
        end
        check("stall_first_valid", 64'(got_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("stall_valid_hold", 64'(m_valid), 64'd1);
            check("stall_data_hold",  64'(m_data),  64'h1122_3344);
        end
        check("stall_reads_issued", 64'(reads_seen - reads_base), 64'd2);
        @(posedge clk) #1 m_ready = 1'b1;
        wait_done("stall");
        check("stall_words", 64'(words_seen - words_base), 64'd3);
        queues_empty("stall");

        // Zero-length burst
        begin
            logic [2:0] b_tr, d_tr, e_tr, v_tr;
            start_burst(32'h0000_0040, 16'd0);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                b_tr[k] = busy;
                d_tr[k] = done;
                e_tr[k] = bram_enable;
                v_tr[k] = m_valid;
            end
            check("zero_busy_trace",   64'(b_tr), 64'h1);
            check("zero_done_trace",   64'(d_tr), 64'h1);
            check("zero_enable_trace", 64'(e_tr), 64'h0);
            check("zero_valid_trace",  64'(v_tr), 64'h0);
        end

        // Address wrap at the top of the address space
        exp_addr.push_back(32'hFFFF_FFFC);
        exp_addr.push_back(32'h0000_0000);
        exp_data.push_back(32'hCAFE_0001);
        exp_data.push_back(32'hCAFE_0002);
        start_burst(32'hFFFF_FFFE, 16'd2);
        wait_done("wrap");
        queues_empty("wrap");

        // Start pulsed mid-burst is ignored
        for (int i = 0; i < 4; i++) begin
            exp_addr.push_back(32'hB000_0000 + 32'(4 * i));
            exp_data.push_back(32'(i + 1));
        end
        reads_base = reads_seen;
        words_base = words_seen;
        start_burst(32'hB000_0000, 16'd4);
        @(posedge clk) #1;
        base_addr  = 32'h0000_0100;
        word_count = 16'd7;
        start      = 1'b1;
        @(posedge clk) #1;
        start      = 1'b0;
        base_addr  = 32'h0000_0200;
        word_count = 16'd9;
        wait_done("restart");
        repeat (5) @(negedge clk);
        check("restart_reads", 64'(reads_seen - reads_base), 64'd4);
        check("restart_words", 64'(words_seen - words_base), 64'd4);
        queues_empty("restart");

        // Reset mid-burst
        for (int i = 0; i < 4; i++) begin
            exp_addr.push_back(32'hB000_0000 + 32'(4 * i));
            exp_data.push_back(32'(i + 1));
        end
        start_burst(32'hB000_0000, 16'd4);
        repeat (3) @(negedge clk);
        @(posedge clk) #1 reset_n = 1'b0;
        #1;
        check("midrst_outputs", 64'({bram_address, bram_enable, m_data, m_valid, busy, done}), 64'd0);
        exp_addr.delete();
        exp_data.delete();
        @(posedge clk) #1 reset_n = 1'b1;
        @(negedge clk);
        check("midrst_release", 64'({m_valid, busy, done}), 64'd0);
        run_basic("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
